mul_pipe: RTL
=============

// Module: mul_pipe
// PURPOSE
//   Parametrised pipelined integer multiplier / multiply-accumulator for the EX stage.
//   Computes signed or unsigned WIDTH x WIDTH -> 2*WIDTH products, optionally added to
//   or subtracted from a 2*WIDTH accumulator (HI/LO MADD/MSUB class ops).
//   Fully pipelined with valid/ready handshakes and an ID tag, so one op issues per cycle.
//   Flush kills in-flight ops on exception or branch squash.
// PARAMETERS
//   WIDTH   32  operand width in bits (>=4)
//   STAGES  5   issue-to-result latency in cycles, no stall (>=1)
//   TAG_W   4   width of the pass-through tag
// PORTS
//   clk        in   1        clock, all state on rising edge
//   rst        in   1        asynchronous reset, active-low
//   flush      in   1        synchronous kill of all in-flight ops
//   in_valid   in   1        op presented
//   in_ready   out  1        op accepted this cycle when in_valid & in_ready
//   in_signed  in   1        1: operands two's complement; 0: unsigned
//   in_acc_op  in   2        00 MUL, 01 MADD (acc+p), 10 MSUB (acc-p), 11 reserved (=MUL)
//   in_a       in   WIDTH    multiplicand
//   in_b       in   WIDTH    multiplier
//   in_acc     in   2*WIDTH  accumulator value, sampled at accept
//   in_tag     in   TAG_W    returned unchanged with result
//   out_valid  out  1        result available
//   out_ready  in   1        consumer takes result when out_valid & out_ready
//   out_res    out  2*WIDTH  result
//   out_tag    out  TAG_W    tag of result op
//   busy       out  1        OR of all stage valid bits
// BEHAVIOUR
//   - Reset (rst=0, async): all stage valid bits 0; out_valid=0, busy=0, out_res=0, out_tag=0.
//     in_ready=0 while rst=0. An op in flight at reset is discarded; no output follows.
//   - Arithmetic: product p = a*b, 2*WIDTH bits, exact. Signed: sign-extended operands.
//     Unsigned: zero-extended operands. MADD: acc+p mod 2^(2W). MSUB: acc-p mod 2^(2W).
//     No overflow flag. (-2^(W-1))^2 = 2^(2W-2) is exact.
//   - Pipeline: STAGES registered stages, each with its own valid bit and payload
//     (partial result, sign/mode, acc, tag). The multiply may be split across stages
//     freely. Result is bit-exact and leaves after exactly STAGES advancing edges.
//   - Stall: advance = ~(out_valid & ~out_ready). in_ready = advance & ~flush.
//     When advance=0, every stage holds, including payload.
//     Bubbles are not compressed: global stall, simple and timing-safe.
//   - Throughput: with out_ready=1, one op per cycle, back-to-back, in order.
//   - Output: out_valid = valid bit of the last stage.
//     out_res/out_tag stay stable while out_valid & ~out_ready.
//   - Flush: on a rising edge with flush=1, all valid bits clear.
//     An op presented the same cycle is not accepted (in_ready=0).
//     A result handshaking that same cycle (out_valid & out_ready) counts as delivered.
//   - Empty pipe: busy=0, out_valid=0, in_ready=1 (unless flush or reset).
//   - Mode 11 behaves as MUL.
//   - Reset, flush and stall priority: reset > flush > stall > advance.
// TESTING (WIDTH=32, STAGES=5, out_ready=1 unless stated)
//   1. Unsigned: a=b=0xFFFFFFFF accepted at cycle 0
//      -> out_valid at cycle 5, out_res=0xFFFFFFFE00000001.
//   2. Signed: -3*7 -> 0xFFFFFFFFFFFFFFEB.
//      Signed 0x80000000*0x80000000 -> 0x4000000000000000.
//      Same operands unsigned -> 0x4000000000000000.
//   3. MADD acc=0x0000000100000000, a=2, b=3 -> 0x0000000100000006.
//      MSUB acc=0, a=b=1 -> 0xFFFFFFFFFFFFFFFF.
//   4. 8 back-to-back ops (tags 0..7), out_ready=0 for cycles 7..9
//      -> in_ready=0 those cycles; all 8 results delivered in tag order;
//      out_res stable during stall; none lost or duplicated.
//   5. 3 ops in flight, flush=1 for one cycle -> no further out_valid, busy=0 next cycle.
//      Op issued after flush appears after exactly 5 cycles.
//   6. rst low at cycle 2 of an op -> out_valid=0 immediately (async).
//      After release, no stale result; new op latency 5.

Source files
------------

// File: rtl/mul_pipe.sv
// Pipelined signed/unsigned WIDTH x WIDTH multiplier with optional accumulate/subtract.
// Global-stall pipeline: every stage holds when the result at the output is not taken.
module mul_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 5,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [1:0]           in_acc_op,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [2*WIDTH-1:0]   in_acc,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_res,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int unsigned PW = 2 * WIDTH;

  logic              advance_c;
  logic              accept_c;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [PW-1:0]     ext_a_c;
  logic [PW-1:0]     ext_b_c;

  // Product of two width-extended operands, truncated to PW bits, then combined with acc.
  function automatic logic [PW-1:0] mac(input logic [PW-1:0] a,
                                        input logic [PW-1:0] b,
                                        input logic [PW-1:0] acc,
                                        input logic [1:0]    op);
    logic [PW-1:0] p;
    p = a * b;
    case (op)
      2'b01:   return acc + p;
      2'b10:   return acc - p;
      default: return p;
    endcase
  endfunction

  assign advance_c = ~(out_valid & ~out_ready);
  assign in_ready  = advance_c & ~flush & rst;
  assign accept_c  = in_valid & in_ready;
  assign out_valid = vld_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign busy      = |vld_q;

  assign ext_a_c = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
  assign ext_b_c = in_signed ? {{WIDTH{in_b[WIDTH-1]}}, in_b} : {{WIDTH{1'b0}}, in_b};

  always_comb begin
    vld_d = vld_q;
    if (flush) begin
      vld_d = '0;
    end else if (advance_c) begin
      vld_d[0] = accept_c;
      for (int unsigned i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        tag_q[i] <= '0;
      end
    end else if (advance_c) begin
      tag_q[0] <= in_tag;
      for (int unsigned i = 1; i < STAGES; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  generate
    if (STAGES == 1) begin : g_one
      logic [PW-1:0] res_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          res_q <= '0;
        end else if (advance_c) begin
          res_q <= mac(ext_a_c, ext_b_c, in_acc, in_acc_op);
        end
      end

      assign out_res = res_q;
    end else begin : g_multi
      // Stage 0 registers operands; stage 1 forms the result; later stages carry it.
      logic [PW-1:0] a_q;
      logic [PW-1:0] b_q;
      logic [PW-1:0] acc_q;
      logic [1:0]    op_q;
      logic [PW-1:0] res_q [STAGES-1];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
          op_q  <= '0;
          for (int unsigned i = 0; i < STAGES - 1; i++) begin
            res_q[i] <= '0;
          end
        end else if (advance_c) begin
          a_q      <= ext_a_c;
          b_q      <= ext_b_c;
          acc_q    <= in_acc;
          op_q     <= in_acc_op;
          res_q[0] <= mac(a_q, b_q, acc_q, op_q);
          for (int unsigned i = 1; i < STAGES - 1; i++) begin
            res_q[i] <= res_q[i-1];
          end
        end
      end

      assign out_res = res_q[STAGES-2];
    end
  endgenerate

endmodule
